// File: rtl/collision_detector_pkg.sv
// Shared constants, FSM state encoding and test indices for the
// per-frame ball collision checker.
package collision_detector_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int BALL_WIDTH    = 16;
  localparam int BALL_HEIGHT   = 16;
  localparam int PADDLE_WIDTH  = 16;
  localparam int PADDLE_HEIGHT = 64;

  localparam logic [2:0] IDX_LEFT     = 3'd0;
  localparam logic [2:0] IDX_RIGHT    = 3'd1;
  localparam logic [2:0] IDX_TOP      = 3'd2;
  localparam logic [2:0] IDX_BOTTOM   = 3'd3;
  localparam logic [2:0] IDX_PLAYER   = 3'd4;
  localparam logic [2:0] IDX_COMPUTER = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_PUBLISH = 2'd2
  } state_e;

endpackage

// File: rtl/collision_detector_box_overlap.sv
// Combinational strict AABB overlap of two boxes; touching edges do not overlap.
module box_overlap #(
  parameter int A_W = 16,
  parameter int A_H = 16,
  parameter int B_W = 16,
  parameter int B_H = 64
) (
  input  logic [15:0] ax,
  input  logic [15:0] ay,
  input  logic [15:0] bx,
  input  logic [15:0] by,
  output logic        overlap
);

  // 17-bit sums so boxes near the coordinate limit never wrap
  logic [16:0] ax_e, ay_e, bx_e, by_e;

  assign ax_e = {1'b0, ax};
  assign ay_e = {1'b0, ay};
  assign bx_e = {1'b0, bx};
  assign by_e = {1'b0, by};

  assign overlap = (ax_e < bx_e + 17'(B_W)) && (bx_e < ax_e + 17'(A_W)) &&
                   (ay_e < by_e + 17'(B_H)) && (by_e < ay_e + 17'(A_H));

endmodule

// File: rtl/collision_detector.sv
// Snapshots object positions on frameEnd, runs one collision test per cycle
// and publishes all six flags together.
//
// state      | meaning
// ST_IDLE    | waiting for frameEnd
// ST_CHECK   | evaluating test idx into shadow bit idx
// ST_PUBLISH | copying shadow flags to outputs, pulsing updated
module collision_detector
  import collision_detector_pkg::*;
(
  input  logic        pixelClock,
  input  logic        resetN,
  input  logic        frameEnd,
  input  logic        enable,
  input  logic [15:0] ballX,
  input  logic [15:0] ballY,
  input  logic [15:0] playerPaddleX,
  input  logic [15:0] playerPaddleY,
  input  logic [15:0] computerPaddleX,
  input  logic [15:0] computerPaddleY,
  output logic        collisionBallScreenLeft,
  output logic        collisionBallScreenRight,
  output logic        collisionBallScreenTop,
  output logic        collisionBallScreenBottom,
  output logic        collisionBallPlayerPaddle,
  output logic        collisionBallComputerPaddle,
  output logic        busy,
  output logic        updated
);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [5:0]  shadow_q, shadow_d;
  logic [5:0]  flags_q, flags_d;
  logic        updated_q, updated_d;
  logic        en_q, en_d;
  logic [15:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [15:0] ply_x_q, ply_x_d, ply_y_q, ply_y_d;
  logic [15:0] cpu_x_q, cpu_x_d, cpu_y_q, cpu_y_d;

  logic [15:0] pad_x, pad_y;
  logic        pad_hit;
  logic        test_bit;

  assign pad_x = (idx_q == IDX_COMPUTER) ? cpu_x_q : ply_x_q;
  assign pad_y = (idx_q == IDX_COMPUTER) ? cpu_y_q : ply_y_q;

  box_overlap #(
    .A_W(BALL_WIDTH),
    .A_H(BALL_HEIGHT),
    .B_W(PADDLE_WIDTH),
    .B_H(PADDLE_HEIGHT)
  ) u_overlap (
    .ax     (ball_x_q),
    .ay     (ball_y_q),
    .bx     (pad_x),
    .by     (pad_y),
    .overlap(pad_hit)
  );

  always_comb begin
    test_bit = 1'b0;
    case (idx_q)
      IDX_LEFT:     test_bit = (ball_x_q == 16'd0);
      IDX_RIGHT:    test_bit = ({1'b0, ball_x_q} + 17'(BALL_WIDTH))  >= 17'(SCREEN_WIDTH);
      IDX_TOP:      test_bit = (ball_y_q == 16'd0);
      IDX_BOTTOM:   test_bit = ({1'b0, ball_y_q} + 17'(BALL_HEIGHT)) >= 17'(SCREEN_HEIGHT);
      IDX_PLAYER,
      IDX_COMPUTER: test_bit = pad_hit;
      default:      test_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    flags_d   = flags_q;
    updated_d = 1'b0;
    en_d      = en_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    ply_x_d   = ply_x_q;
    ply_y_d   = ply_y_q;
    cpu_x_d   = cpu_x_q;
    cpu_y_d   = cpu_y_q;
    case (state_q)
      ST_IDLE: begin
        if (frameEnd) begin
          en_d     = enable;
          ball_x_d = ballX;
          ball_y_d = ballY;
          ply_x_d  = playerPaddleX;
          ply_y_d  = playerPaddleY;
          cpu_x_d  = computerPaddleX;
          cpu_y_d  = computerPaddleY;
          idx_d    = IDX_LEFT;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        shadow_d[idx_q] = en_q & test_bit;
        idx_d = idx_q + 3'd1;
        if (idx_q == IDX_COMPUTER) state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        flags_d   = shadow_q;
        updated_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      shadow_q  <= 6'd0;
      flags_q   <= 6'd0;
      updated_q <= 1'b0;
      en_q      <= 1'b0;
      ball_x_q  <= 16'd0;
      ball_y_q  <= 16'd0;
      ply_x_q   <= 16'd0;
      ply_y_q   <= 16'd0;
      cpu_x_q   <= 16'd0;
      cpu_y_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      flags_q   <= flags_d;
      updated_q <= updated_d;
      en_q      <= en_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      ply_x_q   <= ply_x_d;
      ply_y_q   <= ply_y_d;
      cpu_x_q   <= cpu_x_d;
      cpu_y_q   <= cpu_y_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign updated = updated_q;

  assign collisionBallScreenLeft     = flags_q[IDX_LEFT];
  assign collisionBallScreenRight    = flags_q[IDX_RIGHT];
  assign collisionBallScreenTop      = flags_q[IDX_TOP];
  assign collisionBallScreenBottom   = flags_q[IDX_BOTTOM];
  assign collisionBallPlayerPaddle   = flags_q[IDX_PLAYER];
  assign collisionBallComputerPaddle = flags_q[IDX_COMPUTER];

endmodule

// File: tb/tb_collision_detector.sv
// Scoreboard bench for collision_detector: expected flag vectors are queued
// at frameEnd and compared when updated pulses.
module tb_collision_detector;

  logic        pixelClock = 1'b0;
  logic        resetN = 1'b0;
  logic        frameEnd = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] ballX = '0, ballY = '0;
  logic [15:0] playerPaddleX = '0, playerPaddleY = '0;
  logic [15:0] computerPaddleX = '0, computerPaddleY = '0;
  logic        c_left, c_right, c_top, c_bottom, c_player, c_computer;
  logic        busy, updated;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  always #5 pixelClock = ~pixelClock;

  collision_detector dut (
    .pixelClock                 (pixelClock),
    .resetN                     (resetN),
    .frameEnd                   (frameEnd),
    .enable                     (enable),
    .ballX                      (ballX),
    .ballY                      (ballY),
    .playerPaddleX              (playerPaddleX),
    .playerPaddleY              (playerPaddleY),
    .computerPaddleX            (computerPaddleX),
    .computerPaddleY            (computerPaddleY),
    .collisionBallScreenLeft    (c_left),
    .collisionBallScreenRight   (c_right),
    .collisionBallScreenTop     (c_top),
    .collisionBallScreenBottom  (c_bottom),
    .collisionBallPlayerPaddle  (c_player),
    .collisionBallComputerPaddle(c_computer),
    .busy                       (busy),
    .updated                    (updated)
  );

  wire [5:0] flags = {c_computer, c_player, c_bottom, c_top, c_right, c_left};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic overlap(input int bx, input int by, input int px, input int py);
    return (bx < px + 16) && (px < bx + 16) && (by < py + 64) && (py < by + 16);
  endfunction

  // Bit order: computer, player, bottom, top, right, left
  function automatic logic [5:0] model(input logic en);
    logic [5:0] r;
    int bx, by;
    bx = int'(ballX);
    by = int'(ballY);
    r[0] = (bx == 0);
    r[1] = (bx + 16 >= 640);
    r[2] = (by == 0);
    r[3] = (by + 16 >= 480);
    r[4] = overlap(bx, by, int'(playerPaddleX), int'(playerPaddleY));
    r[5] = overlap(bx, by, int'(computerPaddleX), int'(computerPaddleY));
    return en ? r : 6'd0;
  endfunction

  task automatic set_pos(input int bx, input int by, input int px, input int py,
                         input int cx, input int cy, input logic en);
    ballX = 16'(bx); ballY = 16'(by);
    playerPaddleX = 16'(px); playerPaddleY = 16'(py);
    computerPaddleX = 16'(cx); computerPaddleY = 16'(cy);
    enable = en;
  endtask

  // Pulses frameEnd so it is sampled at edge T0; returns #1 after T0.
  task automatic start_frame();
    @(posedge pixelClock); #1;
    frameEnd = 1'b1;
    exp_q.push_back(model(enable));
    @(posedge pixelClock); #1;
    frameEnd = 1'b0;
    check_val("busy_after_T0", busy, 1);
  endtask

  // Walks edges T1..T7 checking busy/updated, pops the scoreboard at T7.
  task automatic finish_frame(input string tag, input int fe_at, input int bx_at);
    logic [5:0] e;
    bit seen = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge pixelClock); #1;
      if (k == bx_at) ballX = 16'd0;
      if (k + 1 == fe_at) frameEnd = 1'b1;
      if (k == fe_at) frameEnd = 1'b0;
      if (k < 7) begin
        if (updated) begin
          check_val({tag, "_early_updated"}, 1, 0);
        end
        if (k == 6) check_val({tag, "_busy_T6"}, busy, 1);
      end else begin
        seen = updated;
      end
    end
    check_val({tag, "_updated_T7"}, seen, 1);
    check_val({tag, "_busy_T7"}, busy, 0);
    if (exp_q.size() == 0) begin
      check_val({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_flags"}, flags, e);
    end
    @(posedge pixelClock); #1;
    check_val({tag, "_updated_T8"}, updated, 0);
    check_val({tag, "_flags_hold"}, flags, e);
  endtask

  task automatic run(input string tag, input int bx, input int by, input int px,
                     input int py, input int cx, input int cy, input logic en);
    set_pos(bx, by, px, py, cx, cy, en);
    start_frame();
    finish_frame(tag, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge pixelClock);
    #1;
    check_val("reset_flags", flags, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_updated", updated, 0);
    resetN = 1'b1;
    repeat (2) @(posedge pixelClock);

    run("corner00", 0, 0, 0, 100, 624, 100, 1);
    check_val("corner00_const", flags, 6'b000101);

    // Reset mid-CHECK aborts the sequence and clears the published flags
    set_pos(0, 0, 0, 100, 624, 100, 1);
    start_frame();
    repeat (3) @(posedge pixelClock);
    #1;
    resetN = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check_val("midreset_flags", flags, 0);
    check_val("midreset_busy", busy, 0);
    @(posedge pixelClock); #1;
    resetN = 1'b1;
    repeat (10) @(posedge pixelClock);
    #1;
    check_val("postreset_flags", flags, 0);
    check_val("postreset_busy", busy, 0);

    run("after_reset", 0, 0, 0, 100, 624, 100, 1);
    run("center", 312, 232, 0, 100, 624, 100, 1);
    check_val("center_const", flags, 6'b000000);
    run("br_corner", 624, 464, 0, 100, 624, 100, 1);
    check_val("br_const", flags, 6'b001010);
    run("br_inside", 623, 463, 0, 100, 624, 100, 1);
    run("pad_hit", 31, 210, 16, 200, 624, 100, 1);
    check_val("pad_hit_const", flags, 6'b010000);
    run("pad_touch_x", 32, 210, 16, 200, 624, 100, 1);
    run("pad_touch_y", 20, 264, 16, 200, 624, 100, 1);
    run("pad_in_y", 20, 263, 16, 200, 624, 100, 1);
    run("cpu_hit", 610, 150, 16, 200, 624, 100, 1);
    check_val("cpu_hit_const", flags, 6'b100000);
    run("disabled", 0, 0, 0, 0, 624, 100, 0);

    // Extra frameEnd at T3 ignored; ballX change at T2 not seen
    set_pos(5, 50, 16, 200, 624, 100, 1);
    start_frame();
    finish_frame("ignore_fe", 3, 2);
    repeat (10) begin
      @(posedge pixelClock); #1;
      if (updated || busy) check_val("ignore_fe_no_restart", {updated, busy}, 0);
    end
    check_val("ignore_fe_idle", busy, 0);

    for (int i = 0; i < 6; i++) begin
      run("random", int'($urandom_range(0, 640)), int'($urandom_range(0, 480)),
          int'($urandom_range(0, 40)), int'($urandom_range(0, 420)),
          int'($urandom_range(590, 630)), int'($urandom_range(0, 420)), 1'($urandom_range(0, 1)));
    end

    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
